cross_pattern_monitor: RTL and testbench
========================================

Name: cross_pattern_monitor

Overview:
- Receive-side checker for the 12-line LED cross/blink pattern bus.
- Samples the 12 signal lines every clock and detects per-line toggles.
- Classifies lines into two groups: the windowed-blink group (A) and the continuous-blink group (B).
- Per group, reports first/last toggle timestamp, toggle count, state and sticky errors; flags when both groups have gone quiet.

Parameters:
- GRP_A_MASK, 12'hFC3, lines in group A (bit0=signal1 … bit11=signal12; default signals 1,2,7–12).
- GRP_B_MASK, 12'h03C, lines in group B (default signals 3–6).
- QUIET, 4, consecutive event-free samples that end an ACTIVE group (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- sig_in  in  12  pattern lines; bit i = signal(i+1).
- clr  in  1  synchronous clear of all status and the timestamp counter.
- a_state, b_state  out  2 each  group FSM state: 0 IDLE, 1 ACTIVE, 2 DONE.
- a_start, b_start  out  8 each  sample index of the group's first event.
- a_end, b_end  out  8 each  sample index of the group's last accepted event.
- a_count, b_count  out  8 each  accepted events, saturating at 255.
- a_err, b_err  out  1 each  sticky group error.
- unmapped_err  out  1  sticky: a toggle on a line in neither mask.
- all_done  out  1  high while a_state and b_state are both DONE.

Behaviour:
- Reset: every register and output is 0 (states IDLE); s1 = s2 = 0.
- Sampling: s1 <= sig_in and s2 <= s1 every posedge, including during clr.
- Toggle vector: tog = s1 ^ s2.
- Sample numbering: the value captured in s1 at the n-th posedge after reset/clr is sample n.
- Timestamp counter: cyc resets/clears to 0; it increments each posedge, saturating at 255.
- Latency: sample n is evaluated at posedge n+1; its timestamp is n (min(n,255)); outputs reflect it after posedge n+1.
- Group event: any bit of tog & GRP_x_MASK is set.
- Mismatch: an event where the masked toggle bits are not all equal (some group lines toggled, others not) sets x_err; the event still counts.
- Per-group FSM, IDLE:
  - event -> ACTIVE; start = end = n; count = 1; quiet = 0.
- Per-group FSM, ACTIVE:
  - event -> end = n; count +1 (sat 255); quiet = 0.
  - no event -> quiet +1.
  - When quiet reaches QUIET -> DONE. Last event at n means DONE is visible after posedge n+QUIET+1.
- Per-group FSM, DONE:
  - event (retrigger) -> x_err = 1; state, start, end and count unchanged.
  - DONE is left only by clr or reset.
- Unmapped lines: any bit of tog & ~(GRP_A_MASK | GRP_B_MASK) sets unmapped_err; no group is affected.
- Overlapping masks: a line in both masks contributes to both groups.
- Simultaneous events: groups A and B evaluate independently in the same cycle.
- all_done: registered; it rises in the same posedge the second group enters DONE.
- clr:
  - Acts as a synchronous reset of cyc, FSMs, stats, quiet counters, errors and all_done.
  - s1/s2 keep sampling, so a clr never creates a spurious toggle.
  - clr has priority over any event evaluated at the same edge; that event is discarded.
- Reset mid-operation: everything returns to reset values immediately; no partial state is retained.

Test Plan:
1. Reset, hold sig_in = 0 for 20 cycles -> all outputs 0, both states IDLE, all_done = 0.
2. Ideal cross:
   - Group B lines toggle together on samples 1..59; group A lines toggle together on samples 21..41; then hold.
   - Required: a_start = 21, a_end = 41, a_count = 21; b_start = 1, b_end = 59, b_count = 59.
   - Required: a_state = DONE after posedge 46; all_done = 1 after posedge 64; no error flags.
3. Mismatch: only signal3 toggles at sample 5 -> b_state = ACTIVE, b_start = 5, b_count = 1, b_err = 1, a_* unchanged.
4. Retrigger:
   - After scenario 2, toggle group A at sample 80.
   - Required: a_err = 1, a_count stays 21, a_end stays 41, a_state stays DONE, all_done stays 1.
5. Unmapped: with GRP_A_MASK = 12'h003, toggle signal12 at sample 3 -> unmapped_err = 1, both states IDLE, counts 0.
6. Saturation and clr:
   - Idle 300 cycles, then toggle group B -> b_start = 255.
   - Then assert clr one cycle with sig_in held -> all status 0 and IDLE next cycle; no event recorded afterwards.

Source files
------------

// File: rtl/cross_pattern_monitor.sv
// cross_pattern_monitor: receive-side checker for the 12-line LED cross/blink bus,
// tracking per-group toggle timing, counts, FSM state and sticky errors.
module cross_pattern_monitor #(
    parameter logic [11:0] GRP_A_MASK = 12'hFC3,
    parameter logic [11:0] GRP_B_MASK = 12'h03C,
    parameter int          QUIET      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] sig_in,
    input  logic        clr,
    output logic [1:0]  a_state,
    output logic [1:0]  b_state,
    output logic [7:0]  a_start,
    output logic [7:0]  b_start,
    output logic [7:0]  a_end,
    output logic [7:0]  b_end,
    output logic [7:0]  a_count,
    output logic [7:0]  b_count,
    output logic        a_err,
    output logic        b_err,
    output logic        unmapped_err,
    output logic        all_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0][11:0] MASK   = {GRP_B_MASK, GRP_A_MASK};
    localparam logic [11:0]      UNMAP  = ~(GRP_A_MASK | GRP_B_MASK);
    localparam logic [3:0]       Q_LAST = 4'(QUIET - 1);

    logic [11:0]      r_s1, r_s2, w_tog;
    logic [7:0]       r_cyc;
    logic             r_unmapped, r_all_done;
    state_t [1:0]     r_state, w_next;
    logic [1:0][7:0]  r_start, r_end, r_count;
    logic [1:0][3:0]  r_quiet;
    logic [1:0]       r_err, w_ev, w_mis;
    logic [1:0][11:0] w_hit;

    assign w_tog = r_s1 ^ r_s2;

    // A mismatch is an event where only part of the group's lines toggled.
    always_comb begin
        w_hit  = '0;
        w_ev   = '0;
        w_mis  = '0;
        w_next = r_state;
        for (int g = 0; g < 2; g++) begin
            w_hit[g]  = w_tog & MASK[g];
            w_ev[g]   = |w_hit[g];
            w_mis[g]  = w_ev[g] && (w_hit[g] != MASK[g]);
            w_next[g] = clr ? IDLE :
                        (r_state[g] == IDLE && w_ev[g]) ? ACTIVE :
                        (r_state[g] == ACTIVE && !w_ev[g] && r_quiet[g] == Q_LAST) ? DONE :
                        r_state[g];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_cyc      <= '0;
            r_unmapped <= 1'b0;
            r_all_done <= 1'b0;
            r_start    <= '0;
            r_end      <= '0;
            r_count    <= '0;
            r_quiet    <= '0;
            r_err      <= '0;
            for (int g = 0; g < 2; g++)
                r_state[g] <= IDLE;
        end else begin
            r_s1       <= sig_in;
            r_s2       <= r_s1;
            r_cyc      <= clr ? 8'd0 : r_cyc + {7'd0, r_cyc != 8'hFF};
            r_unmapped <= !clr && (r_unmapped || (|(w_tog & UNMAP)));
            r_all_done <= (w_next[0] == DONE) && (w_next[1] == DONE);
            for (int g = 0; g < 2; g++) begin
                r_state[g] <= w_next[g];
                if (clr) begin
                    r_start[g] <= '0;
                    r_end[g]   <= '0;
                    r_count[g] <= '0;
                    r_quiet[g] <= '0;
                    r_err[g]   <= 1'b0;
                end else if (r_state[g] == IDLE) begin
                    if (w_ev[g]) begin
                        r_start[g] <= r_cyc;
                        r_end[g]   <= r_cyc;
                        r_count[g] <= 8'd1;
                        r_quiet[g] <= '0;
                        r_err[g]   <= w_mis[g];
                    end
                end else if (r_state[g] == ACTIVE) begin
                    if (w_ev[g]) begin
                        r_end[g]   <= r_cyc;
                        r_count[g] <= r_count[g] + {7'd0, r_count[g] != 8'hFF};
                        r_quiet[g] <= '0;
                        r_err[g]   <= r_err[g] | w_mis[g];
                    end else begin
                        r_quiet[g] <= r_quiet[g] + 4'd1;
                    end
                end else if (w_ev[g]) begin
                    r_err[g] <= 1'b1;
                end
            end
        end
    end

    assign a_state      = r_state[0];
    assign b_state      = r_state[1];
    assign a_start      = r_start[0];
    assign b_start      = r_start[1];
    assign a_end        = r_end[0];
    assign b_end        = r_end[1];
    assign a_count      = r_count[0];
    assign b_count      = r_count[1];
    assign a_err        = r_err[0];
    assign b_err        = r_err[1];
    assign unmapped_err = r_unmapped;
    assign all_done     = r_all_done;
endmodule

// File: tb/tb_cross_pattern_monitor.sv
// tb_cross_pattern_monitor: scoreboard bench; expected status snapshots are queued
// per posedge index and compared against the DUT one ns after that edge.
module tb_cross_pattern_monitor;
    typedef struct packed {
        logic [1:0] a_st, b_st;
        logic [7:0] a_s, a_e, a_c, b_s, b_e, b_c;
        logic       a_er, b_er, un, dn;
    } snap_t;

    typedef struct {
        int    at;
        int    dut;
        string name;
        snap_t exp;
    } vec_t;

    logic        clk, reset, clr;
    logic [11:0] sig_a, sig_b;
    logic [1:0]  a_state0, b_state0, a_state1, b_state1;
    logic [7:0]  a_start0, b_start0, a_end0, b_end0, a_count0, b_count0;
    logic [7:0]  a_start1, b_start1, a_end1, b_end1, a_count1, b_count1;
    logic        a_err0, b_err0, unm0, done0, a_err1, b_err1, unm1, done1;

    vec_t  q[$];
    int    pc, n_cmp, n_bad, bn, an;
    logic  bv, av;
    snap_t zero;

    cross_pattern_monitor u_dut (
        .clk(clk), .reset(reset), .sig_in(sig_a), .clr(clr),
        .a_state(a_state0), .b_state(b_state0), .a_start(a_start0), .b_start(b_start0),
        .a_end(a_end0), .b_end(b_end0), .a_count(a_count0), .b_count(b_count0),
        .a_err(a_err0), .b_err(b_err0), .unmapped_err(unm0), .all_done(done0)
    );

    cross_pattern_monitor #(.GRP_A_MASK(12'h003)) u_dut2 (
        .clk(clk), .reset(reset), .sig_in(sig_b), .clr(1'b0),
        .a_state(a_state1), .b_state(b_state1), .a_start(a_start1), .b_start(b_start1),
        .a_end(a_end1), .b_end(b_end1), .a_count(a_count1), .b_count(b_count1),
        .a_err(a_err1), .b_err(b_err1), .unmapped_err(unm1), .all_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t get(int d);
        if (d == 0)
            return {a_state0, b_state0, a_start0, a_end0, a_count0,
                    b_start0, b_end0, b_count0, a_err0, b_err0, unm0, done0};
        return {a_state1, b_state1, a_start1, a_end1, a_count1,
                b_start1, b_end1, b_count1, a_err1, b_err1, unm1, done1};
    endfunction

    function automatic snap_t mk(int sa, int s0, int e0, int c0, int er0,
                                 int sb, int s1, int e1, int c1, int er1, int un, int dn);
        snap_t s;
        s.a_st = 2'(sa); s.a_s = 8'(s0); s.a_e = 8'(e0); s.a_c = 8'(c0); s.a_er = 1'(er0);
        s.b_st = 2'(sb); s.b_s = 8'(s1); s.b_e = 8'(e1); s.b_c = 8'(c1); s.b_er = 1'(er1);
        s.un = 1'(un); s.dn = 1'(dn);
        return s;
    endfunction

    task automatic chk(string name, snap_t act, snap_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic add(int at, int d, string name, snap_t e);
        vec_t v;
        v.at = at; v.dut = d; v.name = name; v.exp = e;
        q.push_back(v);
    endtask

    task automatic tick();
        vec_t v;
        @(posedge clk);
        pc++;
        #1;
        while (q.size() > 0 && q[0].at <= pc) begin
            v = q.pop_front();
            if (v.at < pc) begin
                n_cmp++; n_bad++;
                $display("FAIL %s: skipped at edge %0d required edge %0d", v.name, pc, v.at);
            end else begin
                chk(v.name, get(v.dut), v.exp);
            end
        end
    endtask

    task automatic flush();
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL %s: never reached, ended at edge %0d required edge %0d", v.name, pc, v.at);
        end
    endtask

    task automatic do_reset(bit check);
        reset = 1'b1;
        #1;
        if (check) chk("async_reset", get(0), zero);
        #1;
        reset = 1'b0;
        pc = 0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; pc = 0;
        zero = '0;
        reset = 1'b1; clr = 1'b0; sig_a = '0; sig_b = '0;
        #1;
        chk("reset_u1", get(0), zero);
        chk("reset_u2", get(1), zero);
        #1;
        reset = 1'b0;

        // quiet bus after reset
        add(20, 0, "idle20_u1", zero);
        add(20, 1, "idle20_u2", zero);
        for (int n = 1; n <= 20; n++) tick();
        flush();

        // ideal cross followed by a retrigger of group A at sample 80
        do_reset(1'b0);
        add(2,  0, "b_first",    mk(0, 0, 0, 0, 0,    1, 1, 1, 1, 0,   0, 0));
        add(22, 0, "a_first",    mk(1, 21, 21, 1, 0,  1, 1, 21, 21, 0, 0, 0));
        add(42, 0, "a_last",     mk(1, 21, 41, 21, 0, 1, 1, 41, 41, 0, 0, 0));
        add(45, 0, "a_quiet3",   mk(1, 21, 41, 21, 0, 1, 1, 44, 44, 0, 0, 0));
        add(46, 0, "a_done",     mk(2, 21, 41, 21, 0, 1, 1, 45, 45, 0, 0, 0));
        add(63, 0, "b_quiet3",   mk(2, 21, 41, 21, 0, 1, 1, 59, 59, 0, 0, 0));
        add(64, 0, "all_done",   mk(2, 21, 41, 21, 0, 2, 1, 59, 59, 0, 0, 1));
        add(80, 0, "pre_retrig", mk(2, 21, 41, 21, 0, 2, 1, 59, 59, 0, 0, 1));
        add(81, 0, "retrig",     mk(2, 21, 41, 21, 1, 2, 1, 59, 59, 0, 0, 1));
        add(90, 0, "retrig_hold", mk(2, 21, 41, 21, 1, 2, 1, 59, 59, 0, 0, 1));
        for (int n = 1; n <= 90; n++) begin
            bn = (n <= 59) ? n : 59;
            an = (n < 21) ? 0 : (((n <= 41) ? n : 41) - 20);
            bv = bn[0];
            av = an[0] ^ (n >= 80);
            sig_a = (bv ? 12'h03C : 12'h000) | (av ? 12'hFC3 : 12'h000);
            tick();
        end
        flush();

        // mid-operation reset, then partial-group mismatch and an unmapped toggle
        do_reset(1'b1);
        sig_a = '0;
        add(3,  1, "unmap_pre",  zero);
        add(4,  1, "unmap_set",  mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(5,  0, "mis_pre",    zero);
        add(6,  0, "mis_set",    mk(0, 0, 0, 0, 0, 1, 5, 5, 1, 1, 0, 0));
        add(9,  0, "mis_active", mk(0, 0, 0, 0, 0, 1, 5, 5, 1, 1, 0, 0));
        add(10, 0, "mis_done",   mk(0, 0, 0, 0, 0, 2, 5, 5, 1, 1, 0, 0));
        add(12, 1, "unmap_hold", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int n = 1; n <= 12; n++) begin
            sig_a = (n >= 5) ? 12'h004 : 12'h000;
            sig_b = (n >= 3) ? 12'h800 : 12'h000;
            tick();
        end
        flush();

        // timestamp saturation, clr, clr-vs-event priority, count saturation
        do_reset(1'b0);
        sig_a = '0; sig_b = '0;
        add(302, 0, "ts_sat",      mk(0, 0, 0, 0, 0, 1, 255, 255, 1, 0, 0, 0));
        add(303, 0, "clr_zero",    zero);
        add(310, 0, "clr_hold",    zero);
        add(312, 0, "clr_prio",    zero);
        add(313, 0, "clr_prio2",   zero);
        add(314, 0, "post_clr",    mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
        add(573, 0, "cnt_sat",     mk(0, 0, 0, 0, 0, 1, 1, 255, 255, 0, 0, 0));
        add(576, 0, "cnt_quiet3",  mk(0, 0, 0, 0, 0, 1, 1, 255, 255, 0, 0, 0));
        add(577, 0, "cnt_done",    mk(0, 0, 0, 0, 0, 2, 1, 255, 255, 0, 0, 0));
        add(580, 0, "cnt_hold",    mk(0, 0, 0, 0, 0, 2, 1, 255, 255, 0, 0, 0));
        for (int n = 1; n <= 580; n++) begin
            bn = n - 312;
            sig_a = (n <= 300) ? 12'h000 :
                    (n <= 310) ? 12'h03C :
                    (n <= 312) ? 12'h000 :
                    (n <= 572) ? (bn[0] ? 12'h03C : 12'h000) : 12'h000;
            clr = (n == 303) || (n == 312);
            tick();
        end
        clr = 1'b0;
        flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
